// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the alu issue stage: opcodes, instruction fields, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_issue_stage_pkg;

    // Opcodes understood by the downstream 4-bit alu, plus the local load-immediate.
    localparam logic [3:0] OP_NOT  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_XNOR = 4'h6;
    localparam logic [3:0] OP_SHIFT= 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_DIV  = 4'hB;
    localparam logic [3:0] OP_LDI  = 4'hC;

    // Instruction field bit positions; imm overlaps the low bits of rs2.
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Ops D-F have no meaning and retire with an error.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > OP_LDI;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus bundle: instruction handshake, alu operand/result lines, retire and debug read.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates in_valid; other lines are unqualified.
interface alu_issue_stage_if #(
    parameter int DW = 4,
    parameter int RW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_inst;
    logic [DW-1:0]     alu_x;
    logic [DW-1:0]     alu_y;
    logic [3:0]        alu_op;
    logic [DW-1:0]     alu_o;
    logic [2*DW-1:0]   alu_prod;
    logic [DW-1:0]     alu_rem;
    logic              done;
    logic              err;
    logic [RW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;

    // Issue-stage side.
    modport slave (
        input  in_valid, in_inst, alu_o, alu_prod, alu_rem, dbg_addr,
        output in_ready, alu_x, alu_y, alu_op, done, err, dbg_data
    );

    // Instruction source / alu / debug side.
    modport master (
        output in_valid, in_inst, alu_o, alu_prod, alu_rem, dbg_addr,
        input  in_ready, alu_x, alu_y, alu_op, done, err, dbg_data
    );
endinterface

// File: rtl/alu_issue_stage_regfile.sv
// Register file NREGS x DW: two operand reads, one debug read, two write ports.
// Latency: reads combinational, writes take effect at the clock edge.
// Backpressure: none; callers never write the same index on both ports.
module alu_issue_stage_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 4,
    parameter int RW    = $clog2(NREGS)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] i_ra0,
    input  logic [RW-1:0] i_ra1,
    input  logic [RW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_rd0,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_dbg,
    input  logic          i_we0,
    input  logic [RW-1:0] i_wa0,
    input  logic [DW-1:0] i_wd0,
    input  logic          i_we1,
    input  logic [RW-1:0] i_wa1,
    input  logic [DW-1:0] i_wd1
);
    logic [DW-1:0] r_mem [NREGS];

    assign o_rd0 = r_mem[i_ra0];
    assign o_rd1 = r_mem[i_ra1];
    assign o_dbg = r_mem[i_dbg_addr];

    // Storage: cleared on reset, port 1 carries the high half of MUL/DIV pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_we0) r_mem[i_wa0] <= i_wd0;
            if (i_we1) r_mem[i_wa1] <= i_wd1;
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage for the 4-bit alu: reads regs, drives alu, writes results back.
// Latency: done 2 cycles after accept, next accept 3 cycles after accept.
// Backpressure: in_ready high only in IDLE; one instruction in flight.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 4
)(
    input  logic clk,
    input  logic rst,
    alu_issue_stage_if.slave bus
);
    localparam int RW = $clog2(NREGS);

    state_t          r_state;
    logic            r_in_ready;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_alu_x;
    logic [DW-1:0]   r_alu_y;
    logic [3:0]      r_alu_op;
    logic [3:0]      r_op;
    logic [RW-1:0]   r_rd;
    logic [DW-1:0]   r_imm;
    logic [DW-1:0]   r_o;
    logic [DW-1:0]   r_rem;
    logic [2*DW-1:0] r_prod;

    logic [3:0]      w_op;
    logic [RW-1:0]   w_rs1;
    logic [RW-1:0]   w_rs2;
    logic [DW-1:0]   w_rd0;
    logic [DW-1:0]   w_rd1;
    logic            w_accept;
    logic            w_err;
    logic            w_we0;
    logic            w_we1;
    logic [DW-1:0]   w_wd0;
    logic [DW-1:0]   w_wd1;

    assign w_op     = bus.in_inst[OP_HI:OP_LO];
    assign w_rs1    = RW'(bus.in_inst[RS1_HI:RS1_LO]);
    assign w_rs2    = RW'(bus.in_inst[RS2_HI:RS2_LO]);
    assign w_accept = bus.in_valid && r_in_ready;

    // Divide-by-zero is judged on the operand actually presented to the alu.
    assign w_err = op_is_illegal(r_op) || ((r_op == OP_DIV) && (r_alu_y == '0));

    // Writes happen during WB only when the instruction retired cleanly.
    assign w_we0 = (r_state == ST_WB) && !r_err;
    assign w_we1 = w_we0 && ((r_op == OP_MUL) || (r_op == OP_DIV));
    assign w_wd0 = (r_op == OP_LDI) ? r_imm :
                   (r_op == OP_MUL) ? r_prod[DW-1:0] : r_o;
    assign w_wd1 = (r_op == OP_MUL) ? r_prod[2*DW-1:DW] : r_rem;

    assign bus.in_ready = r_in_ready;
    assign bus.alu_x    = r_alu_x;
    assign bus.alu_y    = r_alu_y;
    assign bus.alu_op   = r_alu_op;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

    alu_issue_stage_regfile #(
        .NREGS (NREGS),
        .DW    (DW),
        .RW    (RW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_ra0      (w_rs1),
        .i_ra1      (w_rs2),
        .i_dbg_addr (bus.dbg_addr),
        .o_rd0      (w_rd0),
        .o_rd1      (w_rd1),
        .o_dbg      (bus.dbg_data),
        .i_we0      (w_we0),
        .i_wa0      (r_rd),
        .i_wd0      (w_wd0),
        .i_we1      (w_we1),
        .i_wa1      (r_rd + RW'(1)),
        .i_wd1      (w_wd1)
    );

    // Issue FSM: latch inst and operands on accept, capture alu results in EXEC, retire in WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_alu_x    <= '0;
            r_alu_y    <= '0;
            r_alu_op   <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_o        <= '0;
            r_rem      <= '0;
            r_prod     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_op;
                        r_rd       <= RW'(bus.in_inst[RD_HI:RD_LO]);
                        r_imm      <= DW'(bus.in_inst[IMM_HI:IMM_LO]);
                        r_in_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                        // Only real alu ops disturb the alu lines; LDI and illegal ops leave them.
                        if (w_op <= OP_DIV) begin
                            r_alu_x  <= w_rd0;
                            r_alu_y  <= w_rd1;
                            r_alu_op <= w_op;
                        end
                    end
                end
                ST_EXEC: begin
                    r_o     <= bus.alu_o;
                    r_rem   <= bus.alu_rem;
                    r_prod  <= bus.alu_prod;
                    r_done  <= 1'b1;
                    r_err   <= w_err;
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 4-bit alu attached.
// Latency: checks done 2 cycles after accept and a 3-cycle accept cadence.
// Backpressure: exercises in_valid held high against in_ready.
module tb_alu_issue_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_issue_stage_if #(.DW(4), .RW(3)) bus ();

    alu_issue_stage #(.NREGS(8), .DW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu: combinational results from the registered operands.
    always_comb begin
        bus.alu_o    = 4'h0;
        bus.alu_rem  = 4'h0;
        bus.alu_prod = {4'h0, bus.alu_x} * {4'h0, bus.alu_y};
        case (bus.alu_op)
            4'h0: bus.alu_o = ~bus.alu_x;
            4'h1: bus.alu_o = bus.alu_x & bus.alu_y;
            4'h2: bus.alu_o = ~(bus.alu_x & bus.alu_y);
            4'h3: bus.alu_o = bus.alu_x | bus.alu_y;
            4'h4: bus.alu_o = ~(bus.alu_x | bus.alu_y);
            4'h5: bus.alu_o = bus.alu_x ^ bus.alu_y;
            4'h6: bus.alu_o = ~(bus.alu_x ^ bus.alu_y);
            4'h7: bus.alu_o = bus.alu_x << bus.alu_y[1:0];
            4'h8: bus.alu_o = bus.alu_x + bus.alu_y;
            4'h9: bus.alu_o = bus.alu_x - bus.alu_y;
            4'hB: begin
                if (bus.alu_y != 4'h0) begin
                    bus.alu_o   = bus.alu_x / bus.alu_y;
                    bus.alu_rem = bus.alu_x % bus.alu_y;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [3:0] imm);
        return {4'hC, rd, 5'b00000, imm};
    endfunction

    // Issue one instruction; lat = cycles from accept to done (-1 on timeout). Ends in IDLE.
    task automatic run_inst(input logic [15:0] inst, output int lat, output logic err_seen);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_inst  = 16'($urandom);
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) lat = -1;
        err_seen = bus.err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++; $display("FAIL reset_done_err got %b%b want 00", bus.done, bus.err);
        end
        checks++;
        if (bus.alu_x !== 4'h0 || bus.alu_y !== 4'h0 || bus.alu_op !== 4'h0) begin
            errors++; $display("FAIL reset_alu got x=%h y=%h op=%h want 0 0 0",
                               bus.alu_x, bus.alu_y, bus.alu_op);
        end
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            checks++;
            if (bus.dbg_data !== 4'h0) begin
                errors++; $display("FAIL reset_reg R%0d got %h want 0", i, bus.dbg_data);
            end
        end
    endtask

    task automatic test_logic();
        int lat; logic e;
        run_inst(ldi(3'd1, 4'hF), lat, e);
        run_inst(ldi(3'd2, 4'h3), lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL ldi_lat got lat=%0d err=%b want 2 0", lat, e);
        end
        run_inst(enc(4'h1, 3'd3, 3'd1, 3'd2), lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL and_lat got lat=%0d err=%b want 2 0", lat, e);
        end
        bus.dbg_addr = 3'd3; #1;
        checks++;
        if (bus.dbg_data !== 4'h3) begin
            errors++; $display("FAIL and_R3 got %h want 3", bus.dbg_data);
        end
        run_inst(enc(4'h5, 3'd4, 3'd1, 3'd2), lat, e);
        bus.dbg_addr = 3'd4; #1;
        checks++;
        if (bus.dbg_data !== 4'hC) begin
            errors++; $display("FAIL xor_R4 got %h want c", bus.dbg_data);
        end
        // alu lines keep the XOR operands after retirement.
        checks++;
        if (bus.alu_x !== 4'hF || bus.alu_y !== 4'h3 || bus.alu_op !== 4'h5) begin
            errors++; $display("FAIL alu_hold got x=%h y=%h op=%h want f 3 5",
                               bus.alu_x, bus.alu_y, bus.alu_op);
        end
    endtask

    task automatic test_div();
        int lat; logic e;
        run_inst(ldi(3'd1, 4'hD), lat, e);
        run_inst(ldi(3'd2, 4'h3), lat, e);
        run_inst(enc(4'hB, 3'd4, 3'd1, 3'd2), lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL div_lat got lat=%0d err=%b want 2 0", lat, e);
        end
        bus.dbg_addr = 3'd4; #1;
        checks++;
        if (bus.dbg_data !== 4'h4) begin
            errors++; $display("FAIL div_R4 got %h want 4", bus.dbg_data);
        end
        bus.dbg_addr = 3'd5; #1;
        checks++;
        if (bus.dbg_data !== 4'h1) begin
            errors++; $display("FAIL div_R5 got %h want 1", bus.dbg_data);
        end
        run_inst(enc(4'hB, 3'd4, 3'd1, 3'd0), lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b1) begin
            errors++; $display("FAIL div0_err got lat=%0d err=%b want 2 1", lat, e);
        end
        bus.dbg_addr = 3'd4; #1;
        checks++;
        if (bus.dbg_data !== 4'h4) begin
            errors++; $display("FAIL div0_R4 got %h want 4", bus.dbg_data);
        end
        bus.dbg_addr = 3'd5; #1;
        checks++;
        if (bus.dbg_data !== 4'h1) begin
            errors++; $display("FAIL div0_R5 got %h want 1", bus.dbg_data);
        end
    endtask

    task automatic test_mul();
        int lat; logic e;
        run_inst(ldi(3'd1, 4'hF), lat, e);
        run_inst(ldi(3'd2, 4'hF), lat, e);
        run_inst(enc(4'hA, 3'd6, 3'd1, 3'd2), lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL mul_lat got lat=%0d err=%b want 2 0", lat, e);
        end
        bus.dbg_addr = 3'd6; #1;
        checks++;
        if (bus.dbg_data !== 4'h1) begin
            errors++; $display("FAIL mul_R6 got %h want 1", bus.dbg_data);
        end
        bus.dbg_addr = 3'd7; #1;
        checks++;
        if (bus.dbg_data !== 4'hE) begin
            errors++; $display("FAIL mul_R7 got %h want e", bus.dbg_data);
        end
        run_inst(enc(4'hA, 3'd7, 3'd1, 3'd2), lat, e);
        bus.dbg_addr = 3'd7; #1;
        checks++;
        if (bus.dbg_data !== 4'h1) begin
            errors++; $display("FAIL mulwrap_R7 got %h want 1", bus.dbg_data);
        end
        bus.dbg_addr = 3'd0; #1;
        checks++;
        if (bus.dbg_data !== 4'hE) begin
            errors++; $display("FAIL mulwrap_R0 got %h want e", bus.dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q [3];
        int acc_cyc [3];
        int idx, dones, bad_ready, last_acc;
        logic acc;
        q[0] = enc(4'h8, 3'd3, 3'd1, 3'd6);   // R3 = F + 1 = 0
        q[1] = enc(4'h9, 3'd4, 3'd4, 3'd5);   // R4 = 4 - 1 = 3
        q[2] = enc(4'h8, 3'd5, 3'd4, 3'd4);   // R5 = 3 + 3 = 6, uses fresh R4
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        idx = 0; dones = 0; bad_ready = 0; last_acc = -10;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = q[0];
        for (int c = 0; c < 20; c++) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.done) dones++;
            if ((c - last_acc == 1 || c - last_acc == 2) && bus.in_ready) bad_ready++;
            @(negedge clk);
            if (acc && idx < 3) begin
                acc_cyc[idx] = c;
                last_acc = c;
                idx++;
                if (idx < 3) bus.in_inst = q[idx];
                else         bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (idx !== 3) begin
            errors++; $display("FAIL b2b_accepts got %0d want 3", idx);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin
            errors++; $display("FAIL b2b_spacing got %0d,%0d want 3,3",
                               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
        checks++;
        if (dones !== 3) begin
            errors++; $display("FAIL b2b_done_count got %0d want 3", dones);
        end
        checks++;
        if (bad_ready !== 0) begin
            errors++; $display("FAIL b2b_ready_busy got %0d high cycles want 0", bad_ready);
        end
        bus.dbg_addr = 3'd3; #1;
        checks++;
        if (bus.dbg_data !== 4'h0) begin
            errors++; $display("FAIL b2b_R3 got %h want 0", bus.dbg_data);
        end
        bus.dbg_addr = 3'd4; #1;
        checks++;
        if (bus.dbg_data !== 4'h3) begin
            errors++; $display("FAIL b2b_R4 got %h want 3", bus.dbg_data);
        end
        bus.dbg_addr = 3'd5; #1;
        checks++;
        if (bus.dbg_data !== 4'h6) begin
            errors++; $display("FAIL b2b_R5 got %h want 6", bus.dbg_data);
        end
    endtask

    task automatic test_illegal();
        int lat; logic e;
        logic [3:0] exp_r [8];
        exp_r[0] = 4'hE; exp_r[1] = 4'hF; exp_r[2] = 4'hF; exp_r[3] = 4'h0;
        exp_r[4] = 4'h3; exp_r[5] = 4'h6; exp_r[6] = 4'h1; exp_r[7] = 4'h1;
        run_inst(enc(4'hE, 3'd1, 3'd2, 3'd3), lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b1) begin
            errors++; $display("FAIL illegal_err got lat=%0d err=%b want 2 1", lat, e);
        end
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            checks++;
            if (bus.dbg_data !== exp_r[i]) begin
                errors++; $display("FAIL illegal_reg R%0d got %h want %h", i, bus.dbg_data, exp_r[i]);
            end
        end
        run_inst(enc(4'h8, 3'd2, 3'd6, 3'd7), lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL post_illegal_add got lat=%0d err=%b want 2 0", lat, e);
        end
        bus.dbg_addr = 3'd2; #1;
        checks++;
        if (bus.dbg_data !== 4'h2) begin
            errors++; $display("FAIL post_illegal_R2 got %h want 2", bus.dbg_data);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = enc(4'h8, 3'd1, 3'd1, 3'd1);
        @(negedge clk);                      // now in EXEC
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rst_async got ready=%b done=%b want 1 0", bus.in_ready, bus.done);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL rst_no_done got %0d pulses want 0", dones);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            checks++;
            if (bus.dbg_data !== 4'h0) begin
                errors++; $display("FAIL rst_reg R%0d got %h want 0", i, bus.dbg_data);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_inst  = 16'h0;
        bus.dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_logic();
        test_div();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
